// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first word transmitter with bit-valid, bit period and 7-seg state code
// Define SEQ_TX_REPEAT_EN to add repeat_en and back-to-back frame reload from DONE.
module seq_pattern_tx #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
`ifdef SEQ_TX_REPEAT_EN
  input  logic             repeat_en,
`endif
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       st_literal
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, SHIFT = 2'b11, DONE = 2'b10} state_t;
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [7:0]       pre;
  logic             tick;
`ifdef SEQ_TX_REPEAT_EN
  logic [WIDTH-1:0] reload;
`endif
  assign tick = pre == 8'(PRESCALE - 1);
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      pre   <= '0;
`ifdef SEQ_TX_REPEAT_EN
      reload <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          shreg <= data;
          cnt   <= CW'(WIDTH);
          pre   <= '0;
          state <= LOAD;
`ifdef SEQ_TX_REPEAT_EN
          reload <= data;
`endif
        end
        LOAD: state <= SHIFT;
        SHIFT: if (tick) begin
          pre   <= '0;
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= DONE;
        end else begin
          pre <= pre + 8'd1;
        end
        DONE: begin
`ifdef SEQ_TX_REPEAT_EN
          if (repeat_en) begin
            shreg <= reload;
            cnt   <= CW'(WIDTH);
            pre   <= '0;
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Outputs decode only registered state, so start/data never reach them combinationally.
  always_comb begin
    x_valid    = state == SHIFT;
    busy       = state != IDLE;
    done       = state == DONE;
    x_out      = x_valid & shreg[WIDTH-1];
    st_literal = (state == IDLE) ? 8'hC0 : (state == LOAD) ? 8'hF9 : (state == SHIFT) ? 8'hA4 : 8'hB0;
  end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter; the stimulus source for the serial sequence detectors (e.g. the "1100" Mealy detector).
- Captures a parallel word on a start request and shifts it out MSB-first on a single serial line, with a bit-valid qualifier and a programmable bit period.
- Drives a 7-segment status literal for board-level observation.

Parameters:
- WIDTH, 8: number of bits per word; legal range 2..32.
- PRESCALE, 1: clock cycles each serial bit is held; legal range 1..255.

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- start  input  1  transmit request; sampled only in IDLE.
- data  input  WIDTH  word to transmit; captured in the same cycle start is accepted.
- x_out  output  1  serial bit, MSB first.
- x_valid  output  1  high while x_out carries a pattern bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last bit.
- st_literal  output  8  active-low 7-seg code of the current state; bit7 is dp, always 1.

Behaviour:
- Reset: Reset is asynchronous, active-low; clock is Clock.
  - Reset low forces state IDLE, shift register 0, bit counter 0, prescaler 0.
  - Outputs during and after reset: x_out=0, x_valid=0, busy=0, done=0, st_literal=8'b1100_0000.
  - Reset low mid-transfer aborts immediately. No partial word resumes.
- Gray-coded state register, 2 bits: IDLE=00, LOAD=01, SHIFT=11, DONE=10.
- All outputs are registered or decoded from the state register only. No combinational path from start or data to any output.
- IDLE:
  - If start=1 at a rising edge: capture data into shift register, load bit counter=WIDTH, clear prescaler, go to LOAD.
  - Otherwise remain in IDLE.
- LOAD:
  - One cycle. x_valid=0, busy=1.
  - Always go to SHIFT.
- SHIFT:
  - x_out = shreg[WIDTH-1], x_valid=1.
  - Prescaler counts 0..PRESCALE-1; tick = (prescaler == PRESCALE-1).
  - On tick: prescaler clears, shreg shifts left with 0 fill, counter decrements.
  - On a tick with counter==1: go to DONE.
  - Each bit is held exactly PRESCALE cycles.
  - The first bit appears in the 2nd cycle after the edge that accepted start.
- DONE:
  - One cycle. done=1, x_valid=0, x_out=0.
  - Go to IDLE (see optional feature for the alternative).
- start outside IDLE, including in DONE, is ignored; it is not queued.
- x_out=0 whenever x_valid=0.
- st_literal codes: IDLE 8'b1100_0000 ("0"), LOAD 8'b1111_1001 ("1"), SHIFT 8'b1010_0100 ("2"), DONE 8'b1011_0000 ("3").
- Timing: total busy time per word = 1 + WIDTH*PRESCALE + 1 cycles.
- data may change freely after capture without affecting the word in flight.

Optional Feature:
- Macro SEQ_TX_REPEAT_EN.
- Defined:
  - Adds input port repeat (1 bit) after data.
  - The captured word is also held in a reload register.
  - In DONE with repeat=1: shreg is reloaded from the reload register, counter=WIDTH, and the next state is LOAD (done still pulses).
  - This produces continuous back-to-back frames separated by 2 idle-valid cycles (DONE, LOAD).
  - repeat=0 in DONE returns to IDLE.
- Undefined: no repeat port, no reload register; DONE always goes to IDLE.

Test Plan:
- Basic frame. Stimulus: WIDTH=8, PRESCALE=1, data=8'hCC, start pulsed at edge 0. Required: x_valid=1 on cycles 2..9; x_out=1,1,0,0,1,1,0,0; done=1 on cycle 10; busy=1 on cycles 1..10; IDLE on cycle 11.
- Loopback to detector. Stimulus: connect x_out to the 1100 detector input, send 8'hCC. Required: detector y asserts exactly twice, on the 4th and 8th bits.
- Bit period. Stimulus: PRESCALE=3, data=8'hA5. Required: each bit held 3 cycles (1,0,1,0,0,1,0,1); done on cycle 26.
- Start while busy. Stimulus: start held high through a frame, with data changed to 8'h00 mid-frame. Required: first frame unaffected; a new frame begins only from the IDLE cycle after DONE.
- Reset mid-shift. Stimulus: Reset low during bit 4. Required: same cycle x_valid=0, busy=0, st_literal=8'b1100_0000; after release, no output until a new start.
- Repeat (SEQ_TX_REPEAT_EN defined). Stimulus: repeat=1, data=8'h0C. Required: frames repeat with a 2-cycle gap and done pulses every 10 cycles; dropping repeat returns the block to IDLE after the current frame.
